// File: rtl/aurras_pkg.sv
// Shared types and constants for the impulse capture path.
package aurras_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    FIRE    = 2'd2,
    CAPTURE = 2'd3
  } capture_state_t;

  localparam int unsigned AUDIO_W = 16;

endpackage

// File: rtl/impulse_capture_scheduler.sv
// Sequences impulse captures and time-shares the impulse BRAM port between the
// recorder (writer during CAPTURE) and the convolution engine (reader in IDLE).
module impulse_capture_scheduler
  import aurras_pkg::*;
#(
  parameter int unsigned IMPULSE_LENGTH  = 48000,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned TIMEOUT_SAMPLES = 120000
) (
  input  logic                      audio_clk,
  input  logic                      rst_in,
  input  logic                      audio_trigger,
  input  logic                      capture_req,
  input  logic [15:0]               cfg_delay_in,
  output logic                      rec_trigger_out,
  output logic [15:0]               rec_delay_out,
  input  logic                      rec_we_in,
  input  logic [ADDR_WIDTH-1:0]     rec_addr_in,
  input  logic signed [AUDIO_W-1:0] rec_data_in,
  input  logic                      conv_rd_req_in,
  input  logic [ADDR_WIDTH-1:0]     conv_rd_addr_in,
  output logic                      conv_rd_grant_out,
  output logic [ADDR_WIDTH-1:0]     bram_addr_out,
  output logic signed [AUDIO_W-1:0] bram_din_out,
  output logic                      bram_we_out,
  output logic                      busy_out,
  output logic                      impulse_valid_out,
  output logic                      timeout_out
);

  // Counter is sized for whichever bound is larger so the width is always safe.
  localparam int unsigned CntMax = (TIMEOUT_SAMPLES > IMPULSE_LENGTH) ?
                                   TIMEOUT_SAMPLES : IMPULSE_LENGTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_SAMPLES);

  capture_state_t              r_state;
  logic [CntW-1:0]             r_cnt;
  logic                        r_seen_we;
  logic                        r_we_prev;
  logic                        r_trig;
  logic [15:0]                 r_delay;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic signed [AUDIO_W-1:0]   r_din;
  logic                        r_we;
  logic                        r_grant;
  logic                        r_valid;
  logic                        r_timeout;

  logic [15:0] w_delay_clamped;
  logic        w_we_fall;

  // Zero delay would make the recorder's delay-1 compare wrap.
  assign w_delay_clamped = (cfg_delay_in == 16'd0) ? 16'd1 : cfg_delay_in;
  assign w_we_fall       = r_we_prev && !rec_we_in && r_seen_we;

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_seen_we <= 1'b0;
      r_we_prev <= 1'b0;
      r_trig    <= 1'b0;
      r_delay   <= 16'd1;
      r_addr    <= '0;
      r_din     <= '0;
      r_we      <= 1'b0;
      r_grant   <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_we_prev <= rec_we_in;
      r_trig    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr  <= conv_rd_addr_in;
          r_we    <= 1'b0;
          r_grant <= conv_rd_req_in;
          if (capture_req) begin
            r_delay   <= w_delay_clamped;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_seen_we <= 1'b0;
            r_state   <= RELEASE;
          end
        end
        RELEASE: begin
          r_we    <= 1'b0;
          r_grant <= 1'b0;
          r_trig  <= 1'b1;
          r_state <= FIRE;
        end
        FIRE: begin
          r_we    <= 1'b0;
          r_grant <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_addr  <= rec_addr_in;
          r_din   <= rec_data_in;
          r_we    <= rec_we_in;
          r_grant <= 1'b0;
          if (audio_trigger && (r_cnt != CntLimit)) r_cnt <= r_cnt + 1'b1;
          if (rec_we_in) r_seen_we <= 1'b1;
          // A saturated counter wins over a coincident write-stream fall.
          if (r_cnt == CntLimit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else if (w_we_fall) begin
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_grant <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rec_trigger_out   = r_trig;
  assign rec_delay_out     = r_delay;
  assign conv_rd_grant_out = r_grant;
  assign bram_addr_out     = r_addr;
  assign bram_din_out      = r_din;
  assign bram_we_out       = r_we;
  assign busy_out          = (r_state != IDLE);
  assign impulse_valid_out = r_valid;
  assign timeout_out       = r_timeout;

endmodule

// File: tb/tb_impulse_capture_scheduler.sv
// Self-checking bench for impulse_capture_scheduler: directed phases with
// randomized port traffic compared against expectations derived in the bench.
module tb_impulse_capture_scheduler;

  localparam int unsigned IL   = 64;
  localparam int unsigned AW   = 16;
  localparam int unsigned TO   = 65700;

  if (TO <= 65535 + IL + 1) begin : g_timeout_too_small
    $fatal(1, "TIMEOUT_SAMPLES too small for IMPULSE_LENGTH");
  end

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic                 audio_trigger;
  logic                 capture_req;
  logic [15:0]          cfg_delay_in;
  logic                 rec_trigger_out;
  logic [15:0]          rec_delay_out;
  logic                 rec_we_in;
  logic [AW-1:0]        rec_addr_in;
  logic signed [15:0]   rec_data_in;
  logic                 conv_rd_req_in;
  logic [AW-1:0]        conv_rd_addr_in;
  logic                 conv_rd_grant_out;
  logic [AW-1:0]        bram_addr_out;
  logic signed [15:0]   bram_din_out;
  logic                 bram_we_out;
  logic                 busy_out;
  logic                 impulse_valid_out;
  logic                 timeout_out;

  int n_checks = 0;
  int n_fail   = 0;

  impulse_capture_scheduler #(
    .IMPULSE_LENGTH  (IL),
    .ADDR_WIDTH      (AW),
    .TIMEOUT_SAMPLES (TO)
  ) dut (
    .audio_clk         (clk),
    .rst_in            (rst_in),
    .audio_trigger     (audio_trigger),
    .capture_req       (capture_req),
    .cfg_delay_in      (cfg_delay_in),
    .rec_trigger_out   (rec_trigger_out),
    .rec_delay_out     (rec_delay_out),
    .rec_we_in         (rec_we_in),
    .rec_addr_in       (rec_addr_in),
    .rec_data_in       (rec_data_in),
    .conv_rd_req_in    (conv_rd_req_in),
    .conv_rd_addr_in   (conv_rd_addr_in),
    .conv_rd_grant_out (conv_rd_grant_out),
    .bram_addr_out     (bram_addr_out),
    .bram_din_out      (bram_din_out),
    .bram_we_out       (bram_we_out),
    .busy_out          (busy_out),
    .impulse_valid_out (impulse_valid_out),
    .timeout_out       (timeout_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a capture and follow it through RELEASE and FIRE into CAPTURE.
  task automatic start_capture(input logic [15:0] cfg, input logic [15:0] exp_delay);
    capture_req  = 1'b1;
    cfg_delay_in = cfg;
    step();
    capture_req  = 1'b0;
    chk("req_busy", {31'd0, busy_out}, 32'd1);
    chk("req_clr_valid", {31'd0, impulse_valid_out}, 32'd0);
    chk("req_clr_timeout", {31'd0, timeout_out}, 32'd0);
    chk("req_no_trig_yet", {31'd0, rec_trigger_out}, 32'd0);
    step();
    chk("trig_at_2", {31'd0, rec_trigger_out}, 32'd1);
    chk("delay_latched", {16'd0, rec_delay_out}, {16'd0, exp_delay});
    chk("release_grant", {31'd0, conv_rd_grant_out}, 32'd0);
    step();
    chk("trig_one_cycle", {31'd0, rec_trigger_out}, 32'd0);
    chk("fire_we", {31'd0, bram_we_out}, 32'd0);
    chk("fire_grant", {31'd0, conv_rd_grant_out}, 32'd0);
  endtask

  initial begin
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_din;
    logic          e_req;
    int            k;

    rst_in          = 1'b1;
    audio_trigger   = 1'b0;
    capture_req     = 1'b0;
    cfg_delay_in    = 16'd0;
    rec_we_in       = 1'b0;
    rec_addr_in     = '0;
    rec_data_in     = '0;
    conv_rd_req_in  = 1'b0;
    conv_rd_addr_in = '0;
    repeat (3) step();

    // Reset values
    chk("rst_trig", {31'd0, rec_trigger_out}, 32'd0);
    chk("rst_delay", {16'd0, rec_delay_out}, 32'd1);
    chk("rst_addr", {16'd0, bram_addr_out}, 32'd0);
    chk("rst_din", {16'd0, bram_din_out}, 32'd0);
    chk("rst_we", {31'd0, bram_we_out}, 32'd0);
    chk("rst_grant", {31'd0, conv_rd_grant_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_valid", {31'd0, impulse_valid_out}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_out}, 32'd0);
    rst_in = 1'b0;

    // Idle reads: directed then random, with recorder noise that must be dropped
    conv_rd_req_in  = 1'b1;
    conv_rd_addr_in = 16'h0123;
    step();
    chk("idle_addr", {16'd0, bram_addr_out}, 32'h0123);
    chk("idle_grant", {31'd0, conv_rd_grant_out}, 32'd1);
    chk("idle_we", {31'd0, bram_we_out}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      conv_rd_req_in  = 1'($urandom);
      conv_rd_addr_in = AW'($urandom);
      rec_we_in       = 1'($urandom);
      rec_addr_in     = AW'($urandom);
      rec_data_in     = 16'($urandom);
      e_req  = conv_rd_req_in;
      e_addr = conv_rd_addr_in;
      step();
      chk("idle_rnd_addr", {16'd0, bram_addr_out}, {16'd0, e_addr});
      chk("idle_rnd_grant", {31'd0, conv_rd_grant_out}, {31'd0, e_req});
      chk("idle_rnd_we", {31'd0, bram_we_out}, 32'd0);
    end
    rec_we_in = 1'b0;

    // Normal capture: delay of 10 samples then an IL-sample write burst
    conv_rd_req_in = 1'b1;
    start_capture(16'd10, 16'd10);
    audio_trigger = 1'b1;
    for (int i = 0; i < 10 + int'(IL); i++) begin
      rec_we_in      = (i >= 10);
      rec_addr_in    = AW'(i - 10);
      rec_data_in    = 16'($urandom);
      conv_rd_addr_in = AW'($urandom);
      e_we   = rec_we_in;
      e_addr = rec_addr_in;
      e_din  = rec_data_in;
      step();
      chk("cap_we", {31'd0, bram_we_out}, {31'd0, e_we});
      chk("cap_addr", {16'd0, bram_addr_out}, {16'd0, e_addr});
      chk("cap_din", {16'd0, bram_din_out}, {16'd0, e_din});
      chk("cap_grant", {31'd0, conv_rd_grant_out}, 32'd0);
      chk("cap_valid", {31'd0, impulse_valid_out}, 32'd0);
      chk("cap_busy", {31'd0, busy_out}, 32'd1);
    end
    rec_we_in = 1'b0;
    step();
    chk("fall_valid", {31'd0, impulse_valid_out}, 32'd1);
    chk("fall_busy", {31'd0, busy_out}, 32'd0);
    chk("fall_we", {31'd0, bram_we_out}, 32'd0);
    chk("fall_grant", {31'd0, conv_rd_grant_out}, 32'd0);
    chk("fall_timeout", {31'd0, timeout_out}, 32'd0);
    step();
    chk("grant_back", {31'd0, conv_rd_grant_out}, 32'd1);
    audio_trigger = 1'b0;

    // Delay clamp and a request ignored while capturing
    start_capture(16'd0, 16'd1);
    capture_req = 1'b1;
    step();
    capture_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ignored_req_trig", {31'd0, rec_trigger_out}, 32'd0);
      chk("ignored_req_busy", {31'd0, busy_out}, 32'd1);
    end
    chk("clamp_delay_held", {16'd0, rec_delay_out}, 32'd1);
    rec_we_in = 1'b1;
    repeat (4) step();
    rec_we_in = 1'b0;
    step();
    chk("clamp_cap_valid", {31'd0, impulse_valid_out}, 32'd1);
    chk("clamp_cap_busy", {31'd0, busy_out}, 32'd0);

    // Timeout: recorder never writes, one strobe per cycle in CAPTURE
    start_capture(16'd5, 16'd5);
    audio_trigger = 1'b1;
    for (int i = 1; i < int'(TO); i++) step();
    chk("to_not_early", {31'd0, timeout_out}, 32'd0);
    chk("to_still_busy", {31'd0, busy_out}, 32'd1);
    k = 0;
    while (!timeout_out && k < 3) begin
      step();
      k++;
    end
    chk("to_flag", {31'd0, timeout_out}, 32'd1);
    chk("to_valid", {31'd0, impulse_valid_out}, 32'd0);
    chk("to_idle", {31'd0, busy_out}, 32'd0);
    audio_trigger = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rec_we_in = (i % 2 == 0);
      step();
      chk("stale_we_drop", {31'd0, bram_we_out}, 32'd0);
      chk("to_sticky", {31'd0, timeout_out}, 32'd1);
    end
    rec_we_in = 1'b0;

    // Reset in the middle of a capture
    start_capture(16'd777, 16'd777);
    audio_trigger = 1'b1;
    rec_we_in     = 1'b1;
    repeat (500) step();
    chk("mid_busy", {31'd0, busy_out}, 32'd1);
    chk("mid_we", {31'd0, bram_we_out}, 32'd1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mrst_busy", {31'd0, busy_out}, 32'd0);
    chk("mrst_we", {31'd0, bram_we_out}, 32'd0);
    chk("mrst_valid", {31'd0, impulse_valid_out}, 32'd0);
    chk("mrst_timeout", {31'd0, timeout_out}, 32'd0);
    chk("mrst_trig", {31'd0, rec_trigger_out}, 32'd0);
    chk("mrst_grant", {31'd0, conv_rd_grant_out}, 32'd0);
    chk("mrst_delay", {16'd0, rec_delay_out}, 32'd1);
    chk("mrst_addr", {16'd0, bram_addr_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
